// File: rtl/seg7_pkg.sv
// Shared constants for the count display: segment patterns, converter states
// and digit/BCD sizing.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 16;
  localparam int BCD_W      = 20;
  localparam int DIG_W      = $clog2(NUM_DIGITS);

  // Active-low patterns, bit order {CG,CF,CE,CD,CC,CB,CA}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_count_display_if.sv
// Bundle between the count source / board pins and the display block.
interface seg7_count_display_if;
  import seg7_pkg::*;

  // No valid/ready: count is level-sampled and compared against the last
  // converted value; busy is high while a conversion runs, and bcd/overflow
  // change only on the cycle busy falls.
  logic [15:0] count;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic [15:0] bcd;
  logic        overflow;
  logic        busy;
  conv_state_t dbg_state;

  modport master (
    output count, blank,
    input  seg, dp, an, bcd, overflow, busy, dbg_state
  );

  modport slave (
    input  count, blank,
    output seg, dp, an, bcd, overflow, busy, dbg_state
  );

endinterface

// File: rtl/seg7_count_display_bin2bcd_seq.sv
// Sequential double-dabble: captures a changed count, runs 16 add-3/shift
// steps and publishes four BCD digits plus an overflow flag.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BIN_W-1:0]  i_count,
  output logic [15:0]       o_bcd,
  output logic              o_overflow,
  output logic              o_busy,
  output conv_state_t       o_state
);

  conv_state_t      r_state;
  conv_state_t      w_next;
  logic [BIN_W-1:0] r_shift;
  logic [BIN_W-1:0] r_last;
  logic [BCD_W-1:0] r_acc;
  logic [BCD_W-1:0] w_acc_adj;
  logic [3:0]       r_step;
  logic             r_stale;
  logic [15:0]      r_bcd;
  logic             r_ovf;
  logic             r_busy;
  logic             w_start;

  assign w_start = r_stale || (i_count != r_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = SHIFT;
      SHIFT:   if (r_step == 4'd15) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_acc_adj = r_acc;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_last  <= '0;
      r_acc   <= '0;
      r_step  <= '0;
      r_stale <= 1'b1;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_shift <= i_count;
            r_last  <= i_count;
            r_acc   <= '0;
            r_step  <= '0;
            r_stale <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          // Adjusted accumulator and binary shift left together as one word
          {r_acc, r_shift} <= {w_acc_adj[BCD_W-2:0], r_shift, 1'b0};
          r_step           <= r_step + 1'b1;
        end
        DONE: begin
          r_bcd  <= r_acc[15:0];
          r_ovf  <= |r_acc[BCD_W-1:16];
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_bcd      = r_bcd;
  assign o_overflow = r_ovf;
  assign o_busy     = r_busy;
  assign o_state    = r_state;

endmodule

// File: rtl/seg7_count_display.sv
// Four-digit multiplexed seven-segment display of a 16-bit count, with
// leading-zero blanking and a dash pattern for values above 9999.
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input logic CLK100MHZ,
  input logic reset,
  seg7_count_display_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] r_refresh;
  logic [DIG_W-1:0] r_digit;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;
  logic             w_wrap;
  logic [15:0]      w_bcd;
  logic             w_ovf;
  logic             w_busy;
  conv_state_t      w_state;
  logic [3:0]       w_nib;
  logic [3:0]       w_zero_from;
  logic [7:0]       w_an_next;
  logic [6:0]       w_seg_next;

  bin2bcd_seq u_bin2bcd (
    .i_clk      (CLK100MHZ),
    .i_rst      (reset),
    .i_count    (bus.count),
    .o_bcd      (w_bcd),
    .o_overflow (w_ovf),
    .o_busy     (w_busy),
    .o_state    (w_state)
  );

  assign w_wrap = (r_refresh == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_refresh <= '0;
      r_digit   <= '0;
    end else if (w_wrap) begin
      r_refresh <= '0;
      r_digit   <= r_digit + 1'b1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // w_zero_from[k]: digit k and every digit above it are zero
  assign w_zero_from[3] = (w_bcd[15:12] == 4'd0);
  assign w_zero_from[2] = (w_bcd[15:8]  == 8'd0);
  assign w_zero_from[1] = (w_bcd[15:4]  == 12'd0);
  assign w_zero_from[0] = (w_bcd        == 16'd0);

  always_comb begin
    w_nib      = w_bcd[{r_digit, 2'b00} +: 4];
    w_an_next  = ~(8'h01 << r_digit);
    w_seg_next = seg_pattern(w_nib);
    if (w_ovf) begin
      w_seg_next = SEG_DASH;
    end else if (LZ_SUPPRESS && (r_digit != '0) && w_zero_from[r_digit]) begin
      w_an_next  = 8'hFF;
      w_seg_next = SEG_OFF;
    end
    if (bus.blank) begin
      w_an_next  = 8'hFF;
      w_seg_next = SEG_OFF;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_an  <= 8'hFF;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign bus.seg       = r_seg;
  assign bus.an        = r_an;
  assign bus.dp        = 1'b1;
  assign bus.bcd       = w_bcd;
  assign bus.overflow  = w_ovf;
  assign bus.busy      = w_busy;
  assign bus.dbg_state = w_state;

endmodule

// File: tb/tb_seg7_count_display.sv
// Bench for seg7_count_display: two instances (leading-zero blanking on/off)
// with a conversion scoreboard and a refresh-slot display monitor.
module tb_seg7_count_display;
  import seg7_pkg::*;

  localparam int W = 17;

  logic        clk;
  logic        reset;
  logic [15:0] count;
  logic        blank;

  int n_vec  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  int           conv_cnt = 0;
  logic         busy_prev = 1'b0;
  logic         rst_at_edge = 1'b1;

  logic [1:0]   m_cnt;
  logic [1:0]   m_dig;
  logic [1:0]   m_shown;

  bit           disp_en = 1'b0;
  bit           disp_blank = 1'b0;
  int           disp_value = 0;

  seg7_count_display_if bus_lz ();
  seg7_count_display_if bus_nz ();

  assign bus_lz.count = count;
  assign bus_lz.blank = blank;
  assign bus_nz.count = count;
  assign bus_nz.blank = blank;

  seg7_count_display #(.REFRESH_DIV(4), .LZ_SUPPRESS(1'b1)) u_dut_lz (
    .CLK100MHZ (clk),
    .reset     (reset),
    .bus       (bus_lz)
  );

  seg7_count_display #(.REFRESH_DIV(4), .LZ_SUPPRESS(1'b0)) u_dut_nz (
    .CLK100MHZ (clk),
    .reset     (reset),
    .bus       (bus_nz)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference models ----------------
  function automatic logic [6:0] tb_pat(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [14:0] exp_slot(input int value, input int k, input bit lz, input bit blk);
    logic [7:0] one_hot;
    int scale;
    one_hot = 8'h01 << k;
    scale = 1;
    for (int i = 0; i < k; i++) scale = scale * 10;
    if (blk) return {8'hFF, 7'h7F};
    if (value > 9999) return {~one_hot, 7'h3F};
    if (lz && k > 0 && (value / scale) == 0) return {8'hFF, 7'h7F};
    return {~one_hot, tb_pat((value / scale) % 10)};
  endfunction

  always @(posedge clk) begin
    rst_at_edge <= reset;
    if (reset) begin
      m_cnt <= 2'd0;
      m_dig <= 2'd0;
    end else begin
      m_cnt <= m_cnt + 2'd1;
      if (m_cnt == 2'd3) m_dig <= m_dig + 2'd1;
    end
    m_shown <= m_dig;
  end

  // ---------------- scoreboard: published conversions ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (busy_prev === 1'b1 && bus_lz.busy === 1'b0 && !rst_at_edge) begin
      conv_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL conv_unexpected: got ovf=%b bcd=%h, none expected", bus_lz.overflow, bus_lz.bcd);
      end else begin
        e = exp_q.pop_front();
        if ({bus_lz.overflow, bus_lz.bcd} !== e || {bus_nz.overflow, bus_nz.bcd} !== e) begin
          n_fail++;
          $display("FAIL conv_result: got lz ovf=%b bcd=%h nz ovf=%b bcd=%h, want ovf=%b bcd=%h",
                   bus_lz.overflow, bus_lz.bcd, bus_nz.overflow, bus_nz.bcd, e[16], e[15:0]);
        end
      end
    end
    busy_prev = bus_lz.busy;
  end

  // ---------------- display monitor ----------------
  always @(negedge clk) begin
    logic [14:0] e_lz;
    logic [14:0] e_nz;
    if (disp_en) begin
      e_lz = exp_slot(disp_value, int'(m_shown), 1'b1, disp_blank);
      e_nz = exp_slot(disp_value, int'(m_shown), 1'b0, disp_blank);
      n_vec++;
      if ({bus_lz.an, bus_lz.seg} !== e_lz || bus_lz.dp !== 1'b1) begin
        n_fail++;
        $display("FAIL disp_lz val=%0d slot=%0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1",
                 disp_value, m_shown, bus_lz.an, bus_lz.seg, bus_lz.dp, e_lz[14:7], e_lz[6:0]);
      end
      n_vec++;
      if ({bus_nz.an, bus_nz.seg} !== e_nz || bus_nz.dp !== 1'b1) begin
        n_fail++;
        $display("FAIL disp_nz val=%0d slot=%0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1",
                 disp_value, m_shown, bus_nz.an, bus_nz.seg, bus_nz.dp, e_nz[14:7], e_nz[6:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_count(input logic [15:0] v);
    @(posedge clk);
    #1 count = v;
  endtask

  task automatic show(input int value, input bit blk);
    repeat (2) @(posedge clk);
    disp_value = value;
    disp_blank = blk;
    disp_en    = 1'b1;
    repeat (16) @(posedge clk);
    disp_en    = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    int n_busy;
    int k;
    reset = 1'b1;
    count = 16'd0;
    blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus_lz.seg !== 7'h7F || bus_lz.an !== 8'hFF || bus_lz.dp !== 1'b1 || bus_lz.bcd !== 16'h0 ||
        bus_lz.overflow !== 1'b0 || bus_lz.busy !== 1'b0 || bus_nz.an !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_values: seg=%h an=%h dp=%b bcd=%h ovf=%b busy=%b nz_an=%h, want 7f ff 1 0000 0 0 ff",
               bus_lz.seg, bus_lz.an, bus_lz.dp, bus_lz.bcd, bus_lz.overflow, bus_lz.busy, bus_nz.an);
    end
    exp_q.push_back({1'b0, 16'h0000});
    @(posedge clk);
    #1 reset = 1'b0;
    n_busy = 0;
    k = 0;
    while (k < 60) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus_lz.busy === 1'b1) n_busy++;
      else if (n_busy > 0) break;
    end
    n_vec++;
    if (n_busy != 17 || k != 18) begin
      n_fail++;
      $display("FAIL reset_busy_len: busy cycles=%0d done at edge %0d, want 17 and 18", n_busy, k);
    end
    show(0, 1'b0);
  endtask

  task automatic test_value_1234;
    int k;
    int tgt;
    tgt = conv_cnt + 1;
    exp_q.push_back({1'b0, 16'h1234});
    drive_count(16'd1234);
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus_lz.bcd === 16'h1234) break;
    end
    n_vec++;
    if (k != 18) begin
      n_fail++;
      $display("FAIL latency_1234: bcd valid after %0d cycles, want 18", k);
    end
    for (int i = 0; i < 100 && conv_cnt < tgt; i++) @(negedge clk);
    n_vec++;
    if (conv_cnt < tgt) begin
      n_fail++;
      $display("FAIL wait_1234: conversions=%0d want %0d", conv_cnt, tgt);
    end
    show(1234, 1'b0);
  endtask

  task automatic test_lz;
    int tgt;
    tgt = conv_cnt + 1;
    exp_q.push_back({1'b0, 16'h0007});
    drive_count(16'd7);
    for (int i = 0; i < 100 && conv_cnt < tgt; i++) @(negedge clk);
    n_vec++;
    if (conv_cnt < tgt) begin
      n_fail++;
      $display("FAIL wait_7: conversions=%0d want %0d", conv_cnt, tgt);
    end
    show(7, 1'b0);
  endtask

  task automatic test_overflow;
    int tgt;
    tgt = conv_cnt + 1;
    exp_q.push_back({1'b1, 16'h0000});
    drive_count(16'd10000);
    for (int i = 0; i < 100 && conv_cnt < tgt; i++) @(negedge clk);
    n_vec++;
    if (conv_cnt < tgt || bus_lz.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_10000: conversions=%0d ovf=%b, want %0d and 1", conv_cnt, bus_lz.overflow, tgt);
    end
    show(10000, 1'b0);
    tgt = conv_cnt + 1;
    exp_q.push_back({1'b0, 16'h9999});
    drive_count(16'd9999);
    for (int i = 0; i < 100 && conv_cnt < tgt; i++) @(negedge clk);
    n_vec++;
    if (conv_cnt < tgt || bus_lz.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_9999: conversions=%0d ovf=%b, want %0d and 0", conv_cnt, bus_lz.overflow, tgt);
    end
    show(9999, 1'b0);
  endtask

  task automatic test_back_to_back;
    int tgt;
    int n_low;
    int k;
    tgt = conv_cnt + 2;
    exp_q.push_back({1'b0, 16'h0042});
    exp_q.push_back({1'b0, 16'h0043});
    drive_count(16'd42);
    repeat (5) @(posedge clk);
    #1 count = 16'd43;
    k = 0;
    while (k < 40 && bus_lz.busy !== 1'b0) begin
      @(negedge clk);
      k++;
    end
    n_low = 0;
    k = 0;
    while (k < 10 && bus_lz.busy === 1'b0) begin
      n_low++;
      if (n_low == 1) begin
        n_vec++;
        if (bus_lz.bcd !== 16'h0042) begin
          n_fail++;
          $display("FAIL b2b_first: bcd=%h want 0042", bus_lz.bcd);
        end
      end
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (n_low != 1) begin
      n_fail++;
      $display("FAIL b2b_gap: idle cycles between conversions=%0d want 1", n_low);
    end
    for (int i = 0; i < 100 && conv_cnt < tgt; i++) @(negedge clk);
    n_vec++;
    if (conv_cnt < tgt || bus_lz.bcd !== 16'h0043) begin
      n_fail++;
      $display("FAIL b2b_second: conversions=%0d bcd=%h, want %0d and 0043", conv_cnt, bus_lz.bcd, tgt);
    end
    show(43, 1'b0);
  endtask

  task automatic test_reset_mid;
    int tgt;
    drive_count(16'd500);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus_lz.busy !== 1'b0 || bus_lz.bcd !== 16'h0 || bus_lz.an !== 8'hFF || bus_lz.seg !== 7'h7F ||
        bus_lz.overflow !== 1'b0 || bus_lz.dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b bcd=%h an=%h seg=%h ovf=%b state=%0d, want 0 0000 ff 7f 0 0",
               bus_lz.busy, bus_lz.bcd, bus_lz.an, bus_lz.seg, bus_lz.overflow, bus_lz.dbg_state);
    end
    tgt = conv_cnt + 1;
    exp_q.push_back({1'b0, 16'h0500});
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus_lz.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_restart: busy=%b one cycle after release, want 1", bus_lz.busy);
    end
    for (int i = 0; i < 100 && conv_cnt < tgt; i++) @(negedge clk);
    n_vec++;
    if (conv_cnt < tgt) begin
      n_fail++;
      $display("FAIL wait_500: conversions=%0d want %0d", conv_cnt, tgt);
    end
    show(500, 1'b0);
  endtask

  task automatic test_blank;
    int tgt;
    @(posedge clk);
    #1 blank = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus_lz.an !== 8'hFF || bus_lz.seg !== 7'h7F || bus_nz.an !== 8'hFF || bus_nz.seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL blank_on: lz an=%h seg=%h nz an=%h seg=%h, want ff 7f",
               bus_lz.an, bus_lz.seg, bus_nz.an, bus_nz.seg);
    end
    tgt = conv_cnt + 1;
    exp_q.push_back({1'b0, 16'h0321});
    drive_count(16'd321);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus_lz.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL blank_busy: busy=%b while blanked, want 1", bus_lz.busy);
    end
    for (int i = 0; i < 100 && conv_cnt < tgt; i++) @(negedge clk);
    n_vec++;
    if (conv_cnt < tgt) begin
      n_fail++;
      $display("FAIL wait_321: conversions=%0d want %0d", conv_cnt, tgt);
    end
    show(321, 1'b1);
    @(posedge clk);
    #1 blank = 1'b0;
    show(321, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    count = 16'd0;
    blank = 1'b0;
    test_reset();
    test_value_1234();
    test_lz();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_blank();
    repeat (4) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected conversions never published, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_count_display.md
Name: seg7_count_display

Overview:
- Display-side consumer of the 16-bit game/stopwatch count. It reads the binary count, converts it to BCD with a sequential double-dabble engine, and time-multiplexes four active-low seven-segment digits on the board display.
- Sits between the count register and the board pins `seg`, `dp` and `an`.
- Runs entirely in the CLK100MHZ domain; no derived clocks.

Parameters:
- REFRESH_DIV, 100000, CLK100MHZ cycles each digit stays lit (1 kHz digit rate; set to 4 in simulation).
- LZ_SUPPRESS, 1, 1 = blank leading zero digits; 0 = always show four digits.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- count  input  16  binary value to display, unsigned
- blank  input  1  1 = all anodes off; conversion continues
- seg  output  7  {CG,CF,CE,CD,CC,CB,CA}, active-low
- dp  output  1  decimal point, active-low, held 1 (off)
- an  output  8  digit anodes, active-low; an[0] is the rightmost digit; an[7:4] held 1
- bcd  output  16  last converted digits {d3,d2,d1,d0}
- overflow  output  1  last converted value > 9999
- busy  output  1  conversion in progress

Behaviour:
- Reset values: seg=7'h7F, dp=1, an=8'hFF, bcd=0, overflow=0, busy=0. Internally: FSM=IDLE, digit index=0, refresh counter=0, stale flag=1. The stale flag forces a conversion on the first IDLE cycle after reset.
- Conversion FSM:
  - IDLE: if stale or count != last_value, capture count into the shift register and last_value, clear stale, go to SHIFT, busy=1.
  - SHIFT: 16 cycles. Each cycle adds 3 to every BCD nibble >= 5, then shifts left by 1, in the same cycle. The BCD accumulator is 20 bits (5 digits).
  - DONE: one cycle. Publish bcd = accumulator[15:0] and overflow = (accumulator[19:16] != 0); busy=0; go to IDLE.
- Latency: capture at cycle N; bcd/overflow valid at cycle N+18.
- count changing during SHIFT is ignored. The captured value completes; IDLE sees the mismatch and restarts the next cycle.
- reset mid-conversion aborts to IDLE, returns all outputs to reset values, sets stale.
- Refresh: the counter runs 0..REFRESH_DIV-1 and wraps. On wrap, the digit index advances 0→1→2→3→0.
- seg and an are registered, one cycle after the digit index changes.
- Each digit is shown for exactly REFRESH_DIV cycles.
- Active digit k: an = ~(8'h01 << k), seg = pattern(d_k).
- Patterns:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - dash=7'h3F, off=7'h7F
- overflow=1: every digit shows dash; leading-zero suppression is not applied.
- Leading-zero suppression (LZ_SUPPRESS=1): digit k>0 is suppressed when d_k and all higher digits are 0. A suppressed slot drives an=8'hFF and seg=7'h7F. Digit 0 is never suppressed, so a value of 0 shows "0".
- blank=1: an=8'hFF and seg=7'h7F on the next cycle. The refresh and conversion logic keep running.
- The display uses only published bcd, never the partial accumulator, so there is no tearing mid-conversion.

Decomposition:
- Shared package seg7_pkg holds:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF
  - FSM state encoding IDLE/SHIFT/DONE
  - NUM_DIGITS=4 and the BCD width of 20
- One sub-module, bin2bcd_seq. It contains the capture/compare, the 16-step double-dabble FSM and the busy/done outputs.
- The top level holds the refresh counter, digit mux, leading-zero logic and output registers.

Test Plan (REFRESH_DIV=4):
- Reset release, count=0 → busy for 17 cycles. bcd=16'h0000 at cycle 18. The an[0] slot shows an=8'hFE, seg=7'h40; the other slots show an=8'hFF.
- count=1234 → bcd=16'h1234 18 cycles after capture. Over 16 cycles the outputs cycle: (FE,19), (FD,30), (FB,24), (F7,79), each held for 4 cycles.
- count=7, LZ_SUPPRESS=1 → only the an[0] slot is lit, with seg=7'h78. With LZ_SUPPRESS=0, all four slots are lit, showing 7'h78 and 7'h40 ×3.
- count=10000 → overflow=1, every slot shows seg=7'h3F. Changing count to 9999 gives overflow=0 and bcd=16'h9999.
- count 42→43 at SHIFT cycle 5 → bcd=16'h0042 published first. A second conversion starts 1 cycle later and gives bcd=16'h0043.
- reset asserted at SHIFT cycle 8 → next cycle busy=0, bcd=0, an=8'hFF. After release, a conversion of the current count starts immediately. blank=1 → an=8'hFF within 1 cycle while busy still toggles.
